// File: rtl/sid_pkg.sv
// sid_pkg: command entry format and state encodings shared by the SID command sequencer.
package sid_pkg;
  localparam logic [7:0] CMD_DELAY = 8'h80;
  localparam logic [7:0] CMD_FLUSH = 8'hFF;
  typedef enum logic {CMD_WR = 1'b0, CMD_DLY = 1'b1} cmd_kind_e;
  typedef struct packed {
    cmd_kind_e   kind;
    logic [4:0]  addr;
    logic [15:0] value;
  } sid_cmd_t;
  typedef enum logic [1:0] {P_CMD, P_DATA, P_DLO, P_DHI} p_state_e;
  typedef enum logic [1:0] {X_IDLE, X_FETCH, X_WR, X_DLY} x_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered level, flush, and registered read data (no fall-through).
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             n_reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] dout_q;
  logic             push_ok, pop_ok;
  assign full_o  = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign level_o = level_q;
  assign dout_o  = dout_q;
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      dout_q  <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) begin
        rd_q   <= rd_q + 1'b1;
        dout_q <= mem_q[rd_q];
      end
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/sid_cmd_sequencer.sv
// sid_cmd_sequencer: parses host bytes into SID writes/delays, queues them, and replays them paced by clk_en.
module sid_cmd_sequencer
  import sid_pkg::*;
#(
  parameter int          FIFO_DEPTH = 64,
  parameter int          RTS_MARGIN = 8,
  parameter logic [7:0]  ADDR_MAX   = 8'h1F,
  localparam int         LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          SYS_CLK,
  input  logic          n_reset,
  input  logic          clk_en,
  input  logic [7:0]    in_tdata,
  input  logic          in_tvalid,
  output logic          in_tready,
  output logic [7:0]    sid_addr,
  output logic [7:0]    sid_data,
  output logic          sid_n_cs,
  output logic          rts,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  output logic          busy
);
  p_state_e   p_q;
  x_state_e   x_q;
  logic [4:0] reg_q;
  logic [7:0] lo_q, addr_q, data_q;
  logic [15:0] cnt_q;
  logic       ovf_q, rts_q;
  logic       push, pop, flush, full, empty, wr_now;
  sid_cmd_t   push_cmd, head;
  assign push  = in_tvalid & (p_q == P_DATA | p_q == P_DHI);
  assign flush = in_tvalid & p_q == P_CMD & in_tdata == CMD_FLUSH;
  assign pop   = x_q == X_IDLE & ~empty & ~flush;
  always_comb begin
    push_cmd.kind  = p_q == P_DHI ? CMD_DLY : CMD_WR;
    push_cmd.addr  = p_q == P_DHI ? 5'd0 : reg_q;
    push_cmd.value = p_q == P_DHI ? {in_tdata, lo_q} : {8'h00, in_tdata};
  end
  sync_fifo #(.WIDTH($bits(sid_cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (SYS_CLK),
    .n_reset_i (n_reset),
    .flush_i   (flush),
    .push_i    (push),
    .din_i     (push_cmd),
    .pop_i     (pop),
    .dout_o    (head),
    .level_o   (fifo_level),
    .full_o    (full),
    .empty_o   (empty)
  );
  always_ff @(posedge SYS_CLK or negedge n_reset) begin
    if (!n_reset) begin
      p_q   <= P_CMD;
      reg_q <= '0;
      lo_q  <= '0;
    end else if (in_tvalid) begin
      case (p_q)
        P_CMD: begin
          if (in_tdata <= ADDR_MAX) begin
            reg_q <= in_tdata[4:0];
            p_q   <= P_DATA;
          end else if (in_tdata == CMD_DELAY) p_q <= P_DLO;
        end
        P_DATA: p_q <= P_CMD;
        P_DLO: begin
          lo_q <= in_tdata;
          p_q  <= P_DHI;
        end
        P_DHI: p_q <= P_CMD;
      endcase
    end
  end
  // The strobe is combinational so chip select lines up with the clk_en cycle itself.
  assign wr_now = x_q == X_WR & clk_en;
  always_ff @(posedge SYS_CLK or negedge n_reset) begin
    if (!n_reset) begin
      x_q    <= X_IDLE;
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (wr_now) begin
        addr_q <= {3'b000, head.addr};
        data_q <= head.value[7:0];
      end
      if (flush) x_q <= X_IDLE;
      else begin
        case (x_q)
          X_IDLE: if (!empty) x_q <= X_FETCH;
          X_FETCH: begin
            x_q   <= head.kind == CMD_DLY ? X_DLY : X_WR;
            cnt_q <= head.value;
          end
          X_WR: if (clk_en) x_q <= X_IDLE;
          X_DLY: begin
            if (clk_en) begin
              x_q   <= cnt_q == '0 ? X_IDLE : X_DLY;
              cnt_q <= cnt_q - 1'b1;
            end
          end
        endcase
      end
    end
  end
  always_ff @(posedge SYS_CLK or negedge n_reset) begin
    if (!n_reset) begin
      ovf_q <= 1'b0;
      rts_q <= 1'b1;
    end else begin
      ovf_q <= ovf_q | (push & full);
      rts_q <= (LW'(FIFO_DEPTH) - fifo_level) >= LW'(RTS_MARGIN);
    end
  end
  assign in_tready = 1'b1;
  assign sid_n_cs  = ~wr_now;
  assign sid_addr  = wr_now ? {3'b000, head.addr} : addr_q;
  assign sid_data  = wr_now ? head.value[7:0] : data_q;
  assign rts       = rts_q;
  assign overflow  = ovf_q;
  assign busy      = x_q != X_IDLE | fifo_level != '0;
endmodule

// File: tb/tb_sid_cmd_sequencer.sv
// tb_sid_cmd_sequencer: table-driven vectors plus directed sequences for overflow, flush and reset.
module tb_sid_cmd_sequencer;
  logic       SYS_CLK = 1'b0;
  logic       n_reset = 1'b0;
  logic       gen_en = 1'b0, man_en = 1'b0;
  logic       in_tvalid = 1'b0;
  logic [7:0] in_tdata = 8'h00;
  logic       clk_en;
  logic       in_tready, sid_n_cs, rts, overflow, busy;
  logic [7:0] sid_addr, sid_data;
  logic [6:0] fifo_level;
  int en_period = 0;
  int errors = 0, checks = 0;
  assign clk_en = gen_en | man_en;

  sid_cmd_sequencer dut (
    .SYS_CLK(SYS_CLK), .n_reset(n_reset), .clk_en(clk_en),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .sid_addr(sid_addr), .sid_data(sid_data), .sid_n_cs(sid_n_cs),
    .rts(rts), .fifo_level(fifo_level), .overflow(overflow), .busy(busy)
  );

  initial forever #5 SYS_CLK = ~SYS_CLK;

  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge SYS_CLK);
      #1;
      if (en_period == 0) begin
        gen_en = 1'b0;
        c = 0;
      end else begin
        c = (c + 1 >= en_period) ? 0 : c + 1;
        gen_en = (c == 0);
      end
    end
  end

  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int wt[$];
  int ticks = 0, bad_cs = 0;
  initial begin
    logic prev_low;
    prev_low = 1'b0;
    forever begin
      @(negedge SYS_CLK);
      if (clk_en) ticks++;
      if (!sid_n_cs) begin
        wa.push_back(sid_addr);
        wd.push_back(sid_data);
        wt.push_back(ticks);
        if (prev_low || !clk_en) bad_cs++;
      end
      prev_low = !sid_n_cs;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge SYS_CLK);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b);
    in_tdata = b;
    in_tvalid = 1'b1;
    cyc(1);
    in_tvalid = 1'b0;
  endtask

  task automatic sync_tick(output int t);
    int n;
    n = 0;
    while (!clk_en && n < 200) begin
      cyc(1);
      n++;
    end
    if (n >= 200) chk("tick_timeout", 1, 0);
    cyc(1);
    t = ticks;
  endtask

  task automatic wait_writes(int target, int bound);
    int n;
    n = 0;
    while (wa.size() < target && n < bound) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_addr"}, sid_addr, 8'h00);
    chk({tag, "_data"}, sid_data, 8'h00);
    chk({tag, "_ncs"}, sid_n_cs, 1);
    chk({tag, "_rts"}, rts, 1);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [63:0] bytes;
    int          nb;
    logic [7:0]  ea;
    logic [7:0]  ed;
    int          dt;
  } vec_t;
  vec_t tv[10];

  initial begin
    int t, base, lvl;
    tv[0] = '{64'h0421_0000_0000_0000, 2, 8'h04, 8'h21, 1};
    tv[1] = '{64'h2504_1100_0000_0000, 3, 8'h04, 8'h11, 1};
    tv[2] = '{64'h1FAA_0000_0000_0000, 2, 8'h1F, 8'hAA, 1};
    tv[3] = '{64'h2005_5A00_0000_0000, 3, 8'h05, 8'h5A, 1};
    tv[4] = '{64'h7FFE_13C3_0000_0000, 4, 8'h13, 8'hC3, 1};
    tv[5] = '{64'h00FF_0000_0000_0000, 2, 8'h00, 8'hFF, 1};
    tv[6] = '{64'h0180_0000_0000_0000, 2, 8'h01, 8'h80, 1};
    tv[7] = '{64'h8003_0018_0F00_0000, 5, 8'h18, 8'h0F, 5};
    tv[8] = '{64'h8000_0007_4400_0000, 5, 8'h07, 8'h44, 2};
    tv[9] = '{64'h8001_000A_0B00_0000, 5, 8'h0A, 8'h0B, 3};

    cyc(3);
    chk_reset_vals("init");
    chk("init_tready", in_tready, 1);
    n_reset = 1'b1;
    en_period = 50;
    cyc(2);

    for (int i = 0; i < 10; i++) begin
      sync_tick(t);
      base = wa.size();
      for (int j = 0; j < tv[i].nb; j++) send(tv[i].bytes[63 - 8 * j -: 8]);
      wait_writes(base + 1, 400);
      chk($sformatf("v%0d_count", i), wa.size(), base + 1);
      if (wa.size() > base) begin
        chk($sformatf("v%0d_addr", i), wa[base], tv[i].ea);
        chk($sformatf("v%0d_data", i), wd[base], tv[i].ed);
        chk($sformatf("v%0d_tick", i), wt[base] - t, tv[i].dt);
      end
      cyc(5);
      chk($sformatf("v%0d_once", i), wa.size(), base + 1);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_ovf", i), overflow, 0);
      chk($sformatf("v%0d_hold", i), sid_addr, tv[i].ea);
    end

    // Flush aborts a long delay and discards the queued write.
    sync_tick(t);
    send(8'h80); send(8'hFF); send(8'hFF);
    send(8'h12); send(8'h34);
    cyc(3);
    chk("fl_level_pre", fifo_level, 1);
    chk("fl_busy_pre", busy, 1);
    base = wa.size();
    send(8'hFF);
    chk("fl_level", fifo_level, 0);
    cyc(1);
    chk("fl_busy", busy, 0);
    cyc(300);
    chk("fl_nowrite", wa.size(), base);

    // Flush in the clk_en cycle of a pending write lets that write finish.
    en_period = 0;
    cyc(2);
    send(8'h03); send(8'h77);
    cyc(3);
    chk("fw_busy_pre", busy, 1);
    chk("fw_level_pre", fifo_level, 0);
    base = wa.size();
    in_tdata = 8'hFF; in_tvalid = 1'b1; man_en = 1'b1;
    cyc(1);
    in_tvalid = 1'b0; man_en = 1'b0;
    chk("fw_count", wa.size(), base + 1);
    if (wa.size() > base) chk("fw_data", wd[base], 8'h77);
    chk("fw_busy", busy, 0);

    // Flush while waiting for clk_en drops the write.
    send(8'h03); send(8'h55);
    cyc(3);
    base = wa.size();
    send(8'hFF);
    chk("fn_busy", busy, 0);
    man_en = 1'b1;
    cyc(1);
    man_en = 1'b0;
    cyc(3);
    chk("fn_nowrite", wa.size(), base);

    // Fill with clk_en stopped: one entry sits in the executor, 64 in the FIFO, the 66th overflows.
    base = wa.size();
    for (int k = 1; k <= 66; k++) begin
      send(8'h02);
      send(8'(k - 1));
      cyc(2);
      lvl = (k - 1 > 64) ? 64 : k - 1;
      chk($sformatf("of_level%0d", k), fifo_level, lvl);
      chk($sformatf("of_rts%0d", k), rts, (64 - lvl) >= 8);
      chk($sformatf("of_ovf%0d", k), overflow, k >= 66);
    end
    en_period = 50;
    wait_writes(base + 65, 6000);
    chk("of_count", wa.size(), base + 65);
    for (int i = 0; i < 65; i++) begin
      if (wa.size() > base + i) begin
        chk($sformatf("of_d%0d", i), wd[base + i], 8'(i));
        chk($sformatf("of_a%0d", i), wa[base + i], 8'h02);
      end
    end
    cyc(200);
    chk("of_no66", wa.size(), base + 65);
    chk("of_rts_back", rts, 1);
    chk("of_busy", busy, 0);
    chk("of_sticky", overflow, 1);

    // Asynchronous reset in the middle of a delay with three writes queued.
    sync_tick(t);
    send(8'h80); send(8'h10); send(8'h00);
    send(8'h05); send(8'h01);
    send(8'h05); send(8'h02);
    send(8'h05); send(8'h03);
    cyc(2);
    chk("rs_level_pre", fifo_level, 3);
    chk("rs_busy_pre", busy, 1);
    #2;
    n_reset = 1'b0;
    #1;
    chk_reset_vals("rs");
    cyc(3);
    chk_reset_vals("rs_hold");
    n_reset = 1'b1;
    base = wa.size();
    cyc(300);
    chk("rs_nowrite", wa.size(), base);
    sync_tick(t);
    send(8'h06); send(8'h66);
    wait_writes(base + 1, 400);
    chk("rs_count", wa.size(), base + 1);
    if (wa.size() > base) begin
      chk("rs_addr", wa[base], 8'h06);
      chk("rs_data", wd[base], 8'h66);
      chk("rs_tick", wt[base] - t, 1);
    end

    chk("cs_pulse", bad_cs, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
